// File: rtl/tm_sch_pri_sel_if.sv
// Scheduler priority-select bundle: upstream request, ctrl-memory read port and selection output.
// slave = the selector block, master = whoever drives requests, ctrl memory and downstream.
`ifndef FOURTH_LVL_QUEUE_ID_NBITS
`define FOURTH_LVL_QUEUE_ID_NBITS 8
`endif
`ifndef FOURTH_LVL_SCH_ID_NBITS
`define FOURTH_LVL_SCH_ID_NBITS 6
`endif

interface tm_sch_pri_sel_if #(
    parameter int QID_NBITS   = `FOURTH_LVL_QUEUE_ID_NBITS,
    parameter int DEPTH_NBITS = `FOURTH_LVL_SCH_ID_NBITS
);
    logic                     sch_req;
    logic [DEPTH_NBITS-1:0]   sch_id;
    logic [1:0]               sch_pri_vld;
    logic                     sch_rdy;
    logic                     pri_sch_ctrl_rd;
    logic [DEPTH_NBITS-1:0]   pri_sch_ctrl_raddr;
    logic                     pri_sch_ctrl_ack;
    logic [2*QID_NBITS-1:0]   pri_sch_ctrl_rdata;
    logic                     sel_vld;
    logic                     sel_rdy;
    logic [QID_NBITS-1:0]     sel_qid;
    logic                     sel_pri;
    logic [DEPTH_NBITS-1:0]   sel_sch_id;
    logic                     tmo_err;

    modport slave (
        input  sch_req, sch_id, sch_pri_vld, pri_sch_ctrl_ack, pri_sch_ctrl_rdata, sel_rdy,
        output sch_rdy, pri_sch_ctrl_rd, pri_sch_ctrl_raddr, sel_vld, sel_qid, sel_pri,
               sel_sch_id, tmo_err
    );

    modport master (
        output sch_req, sch_id, sch_pri_vld, pri_sch_ctrl_ack, pri_sch_ctrl_rdata, sel_rdy,
        input  sch_rdy, pri_sch_ctrl_rd, pri_sch_ctrl_raddr, sel_vld, sel_qid, sel_pri,
               sel_sch_id, tmo_err
    );
endinterface

// File: rtl/tm_sch_pri_sel.sv
// Resolves a scheduler id to its highest backlogged queue via a ctrl-memory read; request-to-sel_vld latency 3 cycles minimum.
// Backpressure: sch_rdy drops when the request FIFO is full (extra requests dropped); selection held until sel_rdy.
`ifndef FOURTH_LVL_QUEUE_ID_NBITS
`define FOURTH_LVL_QUEUE_ID_NBITS 8
`endif
`ifndef FOURTH_LVL_SCH_ID_NBITS
`define FOURTH_LVL_SCH_ID_NBITS 6
`endif

module tm_sch_pri_sel #(
    parameter int QID_NBITS   = `FOURTH_LVL_QUEUE_ID_NBITS,
    parameter int DEPTH_NBITS = `FOURTH_LVL_SCH_ID_NBITS,
    parameter int FIFO_NBITS  = 2,
    parameter int TMO_CYCLES  = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    tm_sch_pri_sel_if.slave bus
);
    localparam int FIFO_DEPTH = 1 << FIFO_NBITS;
    localparam int WCNT_NBITS = $clog2(TMO_CYCLES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    // Entries with no backlog are never stored, so pri0==0 implies pri1 is backlogged.
    typedef struct packed {
        logic [DEPTH_NBITS-1:0] sch_id;
        logic                   pri0;
    } req_t;

    req_t                   fifo_mem [FIFO_DEPTH];
    logic [FIFO_NBITS-1:0]  wr_ptr, rd_ptr;
    logic [FIFO_NBITS:0]    fifo_cnt;
    logic [1:0]             state, state_nxt;
    logic [WCNT_NBITS-1:0]  wait_cnt;
    logic                   cur_pri0;
    req_t                   push_req, head_req;
    logic                   push, pop, fifo_empty, ack_hit, tmo_hit, load_head;

    assign push_req       = '{sch_id: bus.sch_id, pri0: bus.sch_pri_vld[0]};
    assign fifo_empty     = (fifo_cnt == '0);
    assign bus.sch_rdy    = (fifo_cnt != (FIFO_NBITS+1)'(FIFO_DEPTH));
    assign push           = bus.sch_req && bus.sch_rdy && (bus.sch_pri_vld != 2'b00);
    assign ack_hit        = (state == ST_WAIT) && bus.pri_sch_ctrl_ack;
    assign tmo_hit        = (state == ST_WAIT) && !bus.pri_sch_ctrl_ack &&
                            (wait_cnt == WCNT_NBITS'(TMO_CYCLES - 1));
    assign pop            = ack_hit || tmo_hit;
    // An empty FIFO being written this cycle presents the incoming request as its head.
    assign head_req       = fifo_empty ? push_req : fifo_mem[rd_ptr];

    assign bus.pri_sch_ctrl_rd = (state == ST_RD);
    assign bus.sel_vld         = (state == ST_OUT);

    always_comb begin
        state_nxt = state;
        load_head = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty || push) begin
                    state_nxt = ST_RD;
                    load_head = 1'b1;
                end
            end
            ST_RD:   state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (ack_hit)      state_nxt = ST_OUT;
                else if (tmo_hit) state_nxt = ST_IDLE;
            end
            ST_OUT: begin
                if (bus.sel_rdy) begin
                    if (!fifo_empty || push) begin
                        state_nxt = ST_RD;
                        load_head = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= ST_IDLE;
            wait_cnt               <= '0;
            cur_pri0               <= 1'b0;
            bus.pri_sch_ctrl_raddr <= '0;
            bus.sel_qid            <= '0;
            bus.sel_pri            <= 1'b0;
            bus.sel_sch_id         <= '0;
            bus.tmo_err            <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
            if (load_head) begin
                bus.pri_sch_ctrl_raddr <= head_req.sch_id;
                cur_pri0               <= head_req.pri0;
            end
            if (ack_hit) begin
                bus.sel_qid    <= cur_pri0 ? bus.pri_sch_ctrl_rdata[QID_NBITS-1:0]
                                           : bus.pri_sch_ctrl_rdata[2*QID_NBITS-1:QID_NBITS];
                bus.sel_pri    <= !cur_pri0;
                bus.sel_sch_id <= bus.pri_sch_ctrl_raddr;
            end
            if (tmo_hit) bus.tmo_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tm_sch_pri_sel.sv
// Bench for tm_sch_pri_sel: transaction-level model plus directed latency, backpressure, timeout and reset cases.
module tb_tm_sch_pri_sel;
    localparam int QW = 8;
    localparam int DW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tm_sch_pri_sel_if #(.QID_NBITS(QW), .DEPTH_NBITS(DW)) bus ();

    tm_sch_pri_sel #(.QID_NBITS(QW), .DEPTH_NBITS(DW), .FIFO_NBITS(2), .TMO_CYCLES(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ctrl memory contents: low half = id^6, high half = id+4 (id 5 -> {9,3}).
    function automatic logic [2*QW-1:0] mem_rd(input logic [DW-1:0] a);
        logic [QW-1:0] lo, hi;
        lo = QW'(a ^ DW'(6));
        hi = QW'(a) + QW'(4);
        return {hi, lo};
    endfunction

    task automatic chk_rst_vals(input string tag);
        chk({tag, "_sch_rdy"}, bus.sch_rdy, 1);
        chk({tag, "_rd"}, bus.pri_sch_ctrl_rd, 0);
        chk({tag, "_raddr"}, bus.pri_sch_ctrl_raddr, 0);
        chk({tag, "_sel_vld"}, bus.sel_vld, 0);
        chk({tag, "_sel_qid"}, bus.sel_qid, 0);
        chk({tag, "_sel_pri"}, bus.sel_pri, 0);
        chk({tag, "_sel_sch_id"}, bus.sel_sch_id, 0);
        chk({tag, "_tmo_err"}, bus.tmo_err, 0);
    endtask

    // ---------------- ctrl-memory responder ----------------
    int ack_dly  = 1;   // cycles from rd to ack; 0 = never ack
    int late_tok = 0;
    int late_done = 0;

    initial begin
        bus.pri_sch_ctrl_ack   = 1'b0;
        bus.pri_sch_ctrl_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.pri_sch_ctrl_rd && ack_dly != 0) begin
                repeat (ack_dly) @(posedge clk);
                #1;
                bus.pri_sch_ctrl_rdata = mem_rd(bus.pri_sch_ctrl_raddr);
                bus.pri_sch_ctrl_ack   = 1'b1;
                @(posedge clk);
                #1 bus.pri_sch_ctrl_ack = 1'b0;
            end else if (late_tok != late_done) begin
                late_done = late_tok;
                @(posedge clk);
                #1;
                bus.pri_sch_ctrl_rdata = mem_rd(DW'(4));
                bus.pri_sch_ctrl_ack   = 1'b1;
                @(posedge clk);
                #1 bus.pri_sch_ctrl_ack = 1'b0;
            end
        end
    end

    // ---------------- transaction-level model + per-cycle compare ----------------
    typedef struct {
        logic [DW-1:0] id;
        logic [1:0]    pri;
    } mreq_t;

    mreq_t          mq[$];
    bit             outst, pend, m_tmo;
    int             ocnt;
    logic [QW-1:0]  e_qid;
    logic           e_pri;
    logic [DW-1:0]  e_sid;
    int             rd_cnt = 0;
    int             acc_cnt = 0;
    logic [DW-1:0]  acc_ids[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk_rst_vals("rst");
            mq.delete();
            outst = 0; pend = 0; m_tmo = 0; ocnt = 0;
        end else begin
            bit    npush;
            mreq_t nreq;
            logic [2*QW-1:0] rdat;
            chk("sch_rdy", bus.sch_rdy, (mq.size() < 4));
            chk("tmo_err", bus.tmo_err, m_tmo);
            chk("sel_vld", bus.sel_vld, pend);
            if (pend && bus.sel_vld) begin
                chk("sel_qid", bus.sel_qid, e_qid);
                chk("sel_pri", bus.sel_pri, e_pri);
                chk("sel_sch_id", bus.sel_sch_id, e_sid);
            end
            if (bus.pri_sch_ctrl_rd) begin
                rd_cnt++;
                chk("rd_allowed", (!outst && !pend && mq.size() > 0), 1);
                if (mq.size() > 0) chk("raddr", bus.pri_sch_ctrl_raddr, mq[0].id);
            end

            npush = bus.sch_req && (mq.size() < 4) && (bus.sch_pri_vld != 2'b00);
            nreq.id  = bus.sch_id;
            nreq.pri = bus.sch_pri_vld;

            if (pend && bus.sel_vld && bus.sel_rdy) begin
                pend = 0;
                acc_cnt++;
                acc_ids.push_back(bus.sel_sch_id);
            end
            if (outst && mq.size() > 0) begin
                if (bus.pri_sch_ctrl_ack) begin
                    rdat  = bus.pri_sch_ctrl_rdata;
                    e_sid = mq[0].id;
                    e_pri = mq[0].pri[0] ? 1'b0 : 1'b1;
                    e_qid = mq[0].pri[0] ? rdat[QW-1:0] : rdat[2*QW-1:QW];
                    void'(mq.pop_front());
                    pend  = 1;
                    outst = 0;
                end else begin
                    ocnt++;
                    if (ocnt == 15) begin
                        m_tmo = 1;
                        void'(mq.pop_front());
                        outst = 0;
                    end
                end
            end
            if (bus.pri_sch_ctrl_rd) begin
                outst = 1;
                ocnt  = 0;
            end
            if (npush) mq.push_back(nreq);
        end
    end

    task automatic drive_req(input int id, input logic [1:0] pri);
        bus.sch_req     = 1'b1;
        bus.sch_id      = DW'(id);
        bus.sch_pri_vld = pri;
    endtask

    // One request, then pinned checks at N+1 (rd) and N+3 (selection).
    task automatic single(input string tag, input int id, input logic [1:0] pri,
                          input int exp_qid, input int exp_pri);
        drive_req(id, pri);
        tick();
        bus.sch_req = 1'b0;
        @(negedge clk);
        chk({tag, "_rd_n1"}, bus.pri_sch_ctrl_rd, 1);
        chk({tag, "_raddr"}, bus.pri_sch_ctrl_raddr, id);
        tick();
        @(negedge clk);
        chk({tag, "_vld_n2"}, bus.sel_vld, 0);
        tick();
        @(negedge clk);
        chk({tag, "_vld_n3"}, bus.sel_vld, 1);
        chk({tag, "_qid"}, bus.sel_qid, exp_qid);
        chk({tag, "_pri"}, bus.sel_pri, exp_pri);
        chk({tag, "_sch_id"}, bus.sel_sch_id, id);
    endtask

    initial begin
        int rd0, acc0, base, waited;
        bus.sch_req     = 1'b0;
        bus.sch_id      = '0;
        bus.sch_pri_vld = 2'b00;
        bus.sel_rdy     = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) tick();

        // Priority-0 and priority-1 selection with minimum latency.
        ack_dly = 1;
        single("p0", 5, 2'b11, 3, 0);
        repeat (3) tick();
        single("p1", 5, 2'b10, 9, 1);
        repeat (3) tick();

        // No backlog: request discarded, no read.
        rd0 = rd_cnt;
        drive_req(6, 2'b00);
        tick();
        bus.sch_req = 1'b0;
        repeat (10) tick();
        chk("pri00_no_rd", rd_cnt - rd0, 0);

        // Fill the FIFO with downstream stalled; the 5th request is dropped.
        ack_dly = 8;
        bus.sel_rdy = 1'b0;
        acc0 = acc_cnt;
        base = acc_ids.size();
        for (int k = 0; k < 5; k++) begin
            drive_req(k + 1, 2'b11);
            @(negedge clk);
            chk("fill_sch_rdy", bus.sch_rdy, (k < 4));
            tick();
        end
        bus.sch_req = 1'b0;
        ack_dly = 1;
        bus.sel_rdy = 1'b1;
        waited = 0;
        while (acc_cnt - acc0 < 4 && waited < 200) begin
            tick();
            waited++;
        end
        repeat (20) tick();
        chk("fill_sel_count", acc_cnt - acc0, 4);
        for (int i = 0; i < 4; i++) begin
            if (acc_ids.size() > base + i) chk("fill_order", acc_ids[base + i], i + 1);
            else chk("fill_order_missing", 0, i + 1);
        end

        // Ack on the 15th WAIT cycle wins over the timeout.
        ack_dly = 15;
        drive_req(3, 2'b01);
        tick();
        bus.sch_req = 1'b0;
        @(negedge clk);
        chk("late_ok_rd", bus.pri_sch_ctrl_rd, 1);
        repeat (15) tick();
        @(negedge clk);
        chk("late_ok_vld_pre", bus.sel_vld, 0);
        tick();
        @(negedge clk);
        chk("late_ok_vld", bus.sel_vld, 1);
        chk("late_ok_qid", bus.sel_qid, 5);
        chk("late_ok_tmo", bus.tmo_err, 0);
        repeat (3) tick();

        // No ack: timeout after 15 WAIT cycles, then normal processing resumes.
        ack_dly = 0;
        drive_req(7, 2'b10);
        tick();
        bus.sch_req = 1'b0;
        repeat (15) tick();
        @(negedge clk);
        chk("tmo_pre", bus.tmo_err, 0);
        tick();
        @(negedge clk);
        chk("tmo_set", bus.tmo_err, 1);
        chk("tmo_no_vld", bus.sel_vld, 0);
        ack_dly = 1;
        repeat (2) tick();
        single("after_tmo", 2, 2'b10, 6, 1);
        chk("tmo_sticky", bus.tmo_err, 1);
        repeat (3) tick();

        // Reset during WAIT, then a stray ack after release.
        ack_dly = 0;
        drive_req(4, 2'b01);
        tick();
        bus.sch_req = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        late_tok++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_rst_vals("post_rst");
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/tm_sch_pri_sel.md
TM_SCH_PRI_SEL -- requirements
Module: tm_sch_pri_sel

Interface
REQ-001 Parameter QID_NBITS, default `FOURTH_LVL_QUEUE_ID_NBITS, queue-id width; ctrl entry width SHALL be 2*QID_NBITS.
REQ-002 Parameter DEPTH_NBITS, default `FOURTH_LVL_SCH_ID_NBITS, scheduler-id and ctrl-memory address width.
REQ-003 Parameter FIFO_NBITS, default 2, request FIFO depth is 2**FIFO_NBITS entries.
REQ-004 Parameter TMO_CYCLES, default 15, maximum number of cycles to wait for a ctrl-memory ack.
REQ-005 clk  in  1  the single clock; all logic is on its rising edge.
REQ-006 `RESET_SIG (rst_n)  in  1  reset, asynchronous assert, active-low.
REQ-007 sch_req  in  1  upstream request valid.
REQ-008 sch_id  in  DEPTH_NBITS  scheduler id to resolve.
REQ-009 sch_pri_vld  in  2  backlog flags; bit0 = priority-0 (high) queue non-empty, bit1 = priority-1 queue non-empty.
REQ-010 sch_rdy  out  1  request FIFO not full.
REQ-011 pri_sch_ctrl_rd  out  1  one-cycle read strobe to ctrl memory.
REQ-012 pri_sch_ctrl_raddr  out  DEPTH_NBITS  read address, equal to sch_id of the head request.
REQ-013 pri_sch_ctrl_ack  in  1  read data valid; arrives 1 or more cycles after pri_sch_ctrl_rd.
REQ-014 pri_sch_ctrl_rdata  in  2*QID_NBITS  [QID_NBITS-1:0] = priority-0 queue id, upper half = priority-1 queue id.
REQ-015 sel_vld  out  1  selection valid.
REQ-016 sel_rdy  in  1  downstream accepts selection.
REQ-017 sel_qid  out  QID_NBITS  selected queue id.
REQ-018 sel_pri  out  1  selected priority (0 high, 1 low).
REQ-019 sel_sch_id  out  DEPTH_NBITS  scheduler id the selection belongs to.
REQ-020 tmo_err  out  1  sticky ack-timeout flag.

Function
REQ-021 A request SHALL be written into the FIFO when sch_req and sch_rdy are both 1; requests with sch_pri_vld==2'b00 SHALL be discarded and not written.
REQ-022 sch_req while the FIFO is full SHALL be dropped; FIFO content and pointers SHALL be unchanged.
REQ-023 FIFO pointers SHALL wrap modulo 2**FIFO_NBITS; simultaneous push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-024 The FSM SHALL have states IDLE, RD, WAIT, OUT.
REQ-025 IDLE -> RD when the FIFO is non-empty; RD asserts pri_sch_ctrl_rd for exactly one cycle, then -> WAIT.
REQ-026 WAIT -> OUT on pri_sch_ctrl_ack; the rdata SHALL be captured in that cycle and the FIFO head popped.
REQ-027 In OUT, sel_vld = 1 and the outputs SHALL remain stable until sel_rdy = 1; on acceptance -> RD if the FIFO is still non-empty (after the pop), else -> IDLE.
REQ-028 Selection rule: if sch_pri_vld[0], sel_qid = rdata[QID_NBITS-1:0] and sel_pri = 0; otherwise sel_qid = upper half of rdata and sel_pri = 1.
REQ-029 Minimum latency: FIFO write at cycle N -> rd at N+1 (from IDLE) -> ack at N+2 at the earliest -> sel_vld at N+3.
REQ-030 Only one read SHALL be outstanding at a time; pri_sch_ctrl_ack outside WAIT SHALL be ignored.
REQ-031 A wait counter SHALL clear on entry to WAIT; if TMO_CYCLES cycles elapse without an ack, tmo_err SHALL be set, the head SHALL be popped and discarded, and the FSM SHALL go to IDLE.
REQ-032 An ack arriving in the same cycle the timeout count is reached SHALL win, and no error SHALL be raised.
REQ-033 tmo_err SHALL be cleared only by reset.

Reset
REQ-034 While rst_n = 0: FSM = IDLE, FIFO empty, sch_rdy = 1, pri_sch_ctrl_rd = 0, sel_vld = 0, tmo_err = 0; sel_qid, sel_pri, sel_sch_id, pri_sch_ctrl_raddr = 0.
REQ-035 Reset asserted mid-operation SHALL abandon any outstanding read; a late ack after reset release SHALL be ignored per REQ-030.

Verification
REQ-036 Single request, sch_id 5, pri_vld 2'b11, ack 1 cycle after rd with rdata {Q=9, Q=3} -> raddr 5, sel_qid 3, sel_pri 0, sel_vld at N+3.
REQ-037 pri_vld 2'b10, same rdata -> sel_qid 9, sel_pri 1; pri_vld 2'b00 -> no rd issued.
REQ-038 Push 5 requests back-to-back with sel_rdy = 0 -> sch_rdy low after 4 pushes, 5th dropped; then hold sel_rdy = 1 -> exactly 4 selections in order.
REQ-039 Never ack -> after 15 WAIT cycles, tmo_err = 1, no sel_vld, next request processed normally.
REQ-040 Ack on exactly the 15th WAIT cycle -> valid selection, tmo_err stays 0.
REQ-041 Assert rst_n low during WAIT, then ack after release -> no sel_vld, all outputs at reset values.
